seg_serial_shifter: RTL
=======================

// Module: seg_serial_shifter
// PURPOSE
//   Sequences 8-digit 7-segment frame output. Captures a DATA_W-bit segment
//   image from the hex-to-segment decoder. Shifts it MSB-first into the
//   board's external serial-in/parallel-out chain, then pulses the chain's
//   latch. Sits between the segment decoder and the top-level display pins.
// PARAMETERS
//   DATA_W   64  bits per frame (8 digits x 8 segments); must be >= 2
//   CLK_DIV  2   clk cycles per seg_clk phase (low and high); must be >= 1
// PORTS
//   clk       in   1       system clock; all logic on rising edge
//   rst       in   1       synchronous reset, active high
//   start     in   1       request a frame transfer; sampled only in IDLE
//   par_data  in   DATA_W  segment image; bit DATA_W-1 is shifted out first
//   busy      out  1       high while a frame is being shifted or latched
//   done      out  1       one-cycle pulse when the frame has been latched
//   seg_clk   out  1       serial shift clock to the external chain
//   seg_sout  out  1       serial data to the external chain
//   seg_pen   out  1       parallel latch enable to the chain, active high
//   seg_clrn  out  1       chain clear, active low
// BEHAVIOUR
//   All outputs are registered.
//   Reset values: busy=0, done=0, seg_clk=0, seg_sout=0, seg_pen=0,
//     seg_clrn=0. The FSM enters IDLE, and the bit counter and phase
//     counter are set to 0.
//   seg_clrn is 0 for every cycle that follows a reset edge. It goes to 1
//     from the first edge at which rst=0.
//   FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
//   IDLE: on start=1 at edge k:
//     - par_data is copied into shreg (later changes are ignored);
//     - bit counter is set to 0;
//     - the FSM goes to SHIFT_LO;
//     - busy=1 from edge k.
//   SHIFT_LO: seg_clk=0 and seg_sout=shreg[DATA_W-1], held for CLK_DIV
//     cycles. Then go to SHIFT_HI.
//   SHIFT_HI: seg_clk=1 and seg_sout is unchanged, held for CLK_DIV cycles.
//     On exit, shreg shifts left by 1 and the bit counter increments.
//     - If DATA_W bits have been sent, go to LATCH.
//     - Otherwise go to SHIFT_LO.
//     Data is therefore stable for a full low phase before each rising edge.
//   LATCH: seg_clk=0, seg_pen=1, held for CLK_DIV cycles. Then go to DONE.
//   DONE: one cycle with done=1, busy=0 and seg_pen=0. Then go to IDLE.
//     start is ignored in this cycle.
//   Latency: busy is high for 2*CLK_DIV*DATA_W + CLK_DIV cycles, and done
//     follows immediately. With defaults: 258 busy cycles, and done is high
//     in the 259th cycle after the start edge.
//   start while busy or in DONE: ignored, not queued.
//   Back-to-back frames: start held high is sampled in the IDLE cycle after
//     DONE, giving one idle cycle between frames.
//   Reset mid-frame: the next edge forces reset values and IDLE. No latch
//     pulse is issued, so the partial frame is never displayed.
//   seg_sout is 0 whenever the FSM is not in SHIFT_LO or SHIFT_HI.
// TESTING
//   1. Reset with rst=1 for 2 cycles, then release.
//      -> All outputs 0 during reset; seg_clrn=1 after release; busy=0.
//   2. par_data=64'h8000_0000_0000_0001, one-cycle start pulse.
//      -> 64 seg_clk rising edges. Sampled seg_sout is 1 at edge 1 and
//         edge 64, 0 elsewhere. seg_pen high 2 cycles. done at cycle 259.
//   3. Drive par_data=64'hA5A5_A5A5_5A5A_5A5A at start, then change it to 0
//      during the shift.
//      -> The bench shift-register model latches 64'hA5A5_A5A5_5A5A_5A5A.
//   4. Pulse start again at cycles 10 and 200 of a frame.
//      -> Both pulses ignored; exactly one done; busy never drops early.
//   5. Assert rst at cycle 100 of a frame.
//      -> Outputs return to reset values next edge; seg_pen never rises;
//         a new start then gives a full 258-cycle frame.
//   6. CLK_DIV=1 and DATA_W=8 with start held high.
//      -> Each frame has busy for 17 cycles, then done for 1 cycle, then
//         1 IDLE cycle. Frames repeat with a 19-cycle period.

Source files
------------

// File: rtl/seg_serial_shifter_if.sv
// Bus between the segment decoder side and the serial display chain.
// Carries the frame request, the segment image and the chain pins.
interface seg_serial_shifter_if #(
   parameter int DATA_W = 64
);
   logic              start;
   logic [DATA_W-1:0] par_data;
   logic              busy;
   logic              done;
   logic              seg_clk;
   logic              seg_sout;
   logic              seg_pen;
   logic              seg_clrn;

   modport master (
      output start,
      output par_data,
      input  busy,
      input  done,
      input  seg_clk,
      input  seg_sout,
      input  seg_pen,
      input  seg_clrn
   );

   modport slave (
      input  start,
      input  par_data,
      output busy,
      output done,
      output seg_clk,
      output seg_sout,
      output seg_pen,
      output seg_clrn
   );
endinterface

// File: rtl/seg_serial_shifter.sv
// Shifts a captured segment image MSB-first into an external SIPO chain,
// then pulses the chain latch. All outputs come straight from flops.
module seg_serial_shifter #(
   parameter int DATA_W  = 64,
   parameter int CLK_DIV = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   seg_serial_shifter_if.slave   bus
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(DATA_W);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_LO,
      SHIFT_HI,
      LATCH,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     ph_q, ph_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;

   logic busy_q, busy_d;
   logic done_q, done_d;
   logic sclk_q, sclk_d;
   logic sout_q, sout_d;
   logic pen_q, pen_d;
   logic clrn_q, clrn_d;

   logic ph_end;
   logic last_bit;

   assign ph_end   = (ph_q == CW'(CLK_DIV - 1));
   assign last_bit = (bit_q == BW'(DATA_W - 1));

   // Next-state, phase/bit counting and shift register update
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               shreg_d = bus.par_data;
               bit_d   = '0;
               ph_d    = '0;
               state_d = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            if (ph_end) begin
               ph_d    = '0;
               state_d = SHIFT_HI;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         SHIFT_HI: begin
            if (ph_end) begin
               ph_d    = '0;
               shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
               bit_d   = bit_q + 1'b1;
               state_d = last_bit ? LATCH : SHIFT_LO;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         LATCH: begin
            if (ph_end) begin
               ph_d    = '0;
               state_d = DONE;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output values decoded from the upcoming state so they land in flops
   always_comb begin
      busy_d = (state_d == SHIFT_LO) || (state_d == SHIFT_HI) ||
               (state_d == LATCH);
      done_d = (state_d == DONE);
      sclk_d = (state_d == SHIFT_HI);
      pen_d  = (state_d == LATCH);
      sout_d = 1'b0;
      if ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) begin
         sout_d = shreg_d[DATA_W-1];
      end
      clrn_d = 1'b1;
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ph_q    <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sclk_q  <= 1'b0;
         sout_q  <= 1'b0;
         pen_q   <= 1'b0;
         clrn_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sclk_q  <= sclk_d;
         sout_q  <= sout_d;
         pen_q   <= pen_d;
         clrn_q  <= clrn_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.seg_clk  = sclk_q;
   assign bus.seg_sout = sout_q;
   assign bus.seg_pen  = pen_q;
   assign bus.seg_clrn = clrn_q;

endmodule
